// File: rtl/writeback_stage.sv
//==============================================================================
// writeback_stage : merges ALU results with queued, aligned load returns onto
//                   the single register-file write port.
// Optional feature macro: WB_FORWARD_EN (bypass of the pending write to op1/op2)
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module writeback_stage #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [2:0]      ld_funct3,
  input  logic [2:0]      ld_addr_lo,
  input  logic [XLEN-1:0] ld_data,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rd_in,
  output logic            rd_we,
  output logic            busy,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [XLEN-1:0] rf_out1,
  input  logic [XLEN-1:0] rf_out2,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [4:0]       q_rd   [DEPTH];
  logic [XLEN-1:0]  q_data [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, push, pop;
  logic [5:0]       shamt;
  logic [XLEN-1:0]  shifted, ext_data;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign ld_ready = !full;
  assign busy     = !empty;
  assign push     = ld_valid && !full;
  assign pop      = !alu_valid && !empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Low address bits below the access size are dropped before selecting the lane.
  always_comb begin
    shamt = 6'd0;
    case (ld_funct3[1:0])
      2'b00:   shamt = {ld_addr_lo, 3'b000};
      2'b01:   shamt = {ld_addr_lo[2:1], 4'b0000};
      2'b10:   shamt = {ld_addr_lo[2], 5'b00000};
      default: shamt = 6'd0;
    endcase
  end

  assign shifted = ld_data >> shamt;

  always_comb begin
    ext_data = ld_data;
    case (ld_funct3)
      3'b000:  ext_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b100:  ext_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b001:  ext_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b101:  ext_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      3'b010:  ext_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      3'b110:  ext_data = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: ext_data = ld_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= ld_rd;
      q_data[wr_ptr] <= ext_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ALU owns the port whenever valid; writes to x0 still consume their slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd    <= '0;
      rd_in <= '0;
      rd_we <= 1'b0;
    end else if (alu_valid) begin
      rd    <= alu_rd;
      rd_in <= alu_data;
      rd_we <= (alu_rd != 5'd0);
    end else if (!empty) begin
      rd    <= q_rd[rd_ptr];
      rd_in <= q_data[rd_ptr];
      rd_we <= (q_rd[rd_ptr] != 5'd0);
    end else begin
      rd_we <= 1'b0;
    end
  end

`ifdef WB_FORWARD_EN
  assign op1 = (rd_we && (rd == rs1) && (rs1 != 5'd0)) ? rd_in : rf_out1;
  assign op2 = (rd_we && (rd == rs2) && (rs2 != 5'd0)) ? rd_in : rf_out2;
`else
  logic unused_rs;
  assign unused_rs = ^{rs1, rs2};
  assign op1 = rf_out1;
  assign op2 = rf_out2;
`endif

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
//==============================================================================
// tb_writeback_stage : randomized and directed checks of writeback_stage
// against a queue-based reference model.
//==============================================================================
`default_nettype none

module tb_writeback_stage;

  localparam int XLEN  = 64;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [2:0]      ld_funct3;
  logic [2:0]      ld_addr_lo;
  logic [XLEN-1:0] ld_data;
  logic [4:0]      rd;
  logic [XLEN-1:0] rd_in;
  logic            rd_we;
  logic            busy;
  logic [4:0]      rs1, rs2;
  logic [XLEN-1:0] rf_out1, rf_out2;
  logic [XLEN-1:0] op1, op2;

  int checks = 0;
  int passed = 0;

  // reference model state
  logic [4:0]      mq_rd[$];
  logic [XLEN-1:0] mq_data[$];
  logic [4:0]      exp_rd;
  logic [XLEN-1:0] exp_rd_in;
  logic            exp_we;

  writeback_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd),
    .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo), .ld_data(ld_data),
    .rd(rd), .rd_in(rd_in), .rd_we(rd_we), .busy(busy),
    .rs1(rs1), .rs2(rs2), .rf_out1(rf_out1), .rf_out2(rf_out2),
    .op1(op1), .op2(op2)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_align(input logic [2:0] f3, input logic [2:0] a,
                                            input logic [63:0] d);
    int unsigned ai;
    logic [63:0] s;
    byte     b;
    shortint h;
    int      w;
    longint  v;
    ai = a;
    case (f3)
      3'd0, 3'd4: s = d >> (8 * ai);
      3'd1, 3'd5: s = d >> (16 * (ai / 2));
      3'd2, 3'd6: s = d >> (32 * (ai / 4));
      default:    s = d;
    endcase
    b = s[7:0];
    h = s[15:0];
    w = s[31:0];
    case (f3)
      3'd0:    v = b;
      3'd4:    v = s & 64'hFF;
      3'd1:    v = h;
      3'd5:    v = s & 64'hFFFF;
      3'd2:    v = w;
      3'd6:    v = s & 64'hFFFF_FFFF;
      default: v = s;
    endcase
    return v;
  endfunction

  // Advance the model by one clock using the inputs currently driven, then
  // move to just after the active edge.
  task automatic tick();
    bit was_room;
    was_room = (mq_rd.size() < DEPTH);
    if (alu_valid) begin
      exp_rd    = alu_rd;
      exp_rd_in = alu_data;
      exp_we    = (alu_rd != 0);
    end else if (mq_rd.size() > 0) begin
      exp_rd    = mq_rd.pop_front();
      exp_rd_in = mq_data.pop_front();
      exp_we    = (exp_rd != 0);
    end else begin
      exp_we = 1'b0;
    end
    if (ld_valid && was_room) begin
      mq_rd.push_back(ld_rd);
      mq_data.push_back(ref_align(ld_funct3, ld_addr_lo, ld_data));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    mq_rd.delete();
    mq_data.delete();
    exp_rd    = '0;
    exp_rd_in = '0;
    exp_we    = 1'b0;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_funct3 = 0; ld_addr_lo = 0; ld_data = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    rs1 = 0; rs2 = 0; rf_out1 = 0; rf_out2 = 0;
    model_clear();
    #12;
    checks++; if (rd_we !== 1'b0) $display("FAIL reset_we got %0b want 0", rd_we); else passed++;
    checks++; if (rd !== 5'd0) $display("FAIL reset_rd got %0d want 0", rd); else passed++;
    checks++; if (rd_in !== '0) $display("FAIL reset_rd_in got %h want 0", rd_in); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passed++;
    checks++; if (ld_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", ld_ready); else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_alu_write();
    alu_valid = 1; alu_rd = 5; alu_data = 64'h1234;
    tick();
    idle_inputs();
    checks++; if (rd !== 5'd5) $display("FAIL alu_rd got %0d want 5", rd); else passed++;
    checks++; if (rd_in !== 64'h1234) $display("FAIL alu_data got %h want 1234", rd_in); else passed++;
    checks++; if (rd_we !== 1'b1) $display("FAIL alu_we got %0b want 1", rd_we); else passed++;
    tick();
    checks++; if (rd_we !== 1'b0) $display("FAIL idle_we got %0b want 0", rd_we); else passed++;
    checks++; if (rd !== 5'd5 || rd_in !== 64'h1234)
      $display("FAIL idle_hold got rd=%0d data=%h want rd=5 data=1234", rd, rd_in); else passed++;
  endtask

  task automatic test_lb_sign();
    ld_valid = 1; ld_rd = 3; ld_funct3 = 3'b000; ld_addr_lo = 3'd1; ld_data = 64'h8000;
    tick();
    idle_inputs();
    tick();
    checks++; if (rd_we !== 1'b1 || rd !== 5'd3 || rd_in !== 64'hFFFF_FFFF_FFFF_FF80)
      $display("FAIL lb_sign got we=%0b rd=%0d data=%h want 1 3 ffffffffffffff80", rd_we, rd, rd_in);
    else passed++;
    ld_valid = 1; ld_rd = 4; ld_funct3 = 3'b100; ld_addr_lo = 3'd1; ld_data = 64'h8000;
    tick();
    idle_inputs();
    tick();
    checks++; if (rd_we !== 1'b1 || rd !== 5'd4 || rd_in !== 64'h80)
      $display("FAIL lbu_zero got we=%0b rd=%0d data=%h want 1 4 80", rd_we, rd, rd_in);
    else passed++;
  endtask

  task automatic test_contention();
    alu_valid = 1; alu_rd = 9; alu_data = 64'h99;
    ld_valid = 1; ld_rd = 10; ld_funct3 = 3'b011; ld_addr_lo = 3'd5; ld_data = 64'hAAAA_0000_0000_000A;
    checks++; if (ld_ready !== 1'b1) $display("FAIL cont_ready0 got %0b want 1", ld_ready); else passed++;
    tick();
    ld_rd = 11; ld_data = 64'hBBBB_0000_0000_000B;
    checks++; if (ld_ready !== 1'b1) $display("FAIL cont_ready1 got %0b want 1", ld_ready); else passed++;
    tick();
    ld_rd = 12; ld_data = 64'hCCCC_0000_0000_000C;
    checks++; if (ld_ready !== 1'b0) $display("FAIL cont_full got %0b want 0", ld_ready); else passed++;
    tick();
    checks++; if (ld_ready !== 1'b0 || busy !== 1'b1 || rd !== 5'd9 || rd_we !== 1'b1)
      $display("FAIL cont_stall got ready=%0b busy=%0b rd=%0d we=%0b want 0 1 9 1", ld_ready, busy, rd, rd_we);
    else passed++;
    idle_inputs();
    tick();
    checks++; if (rd_we !== 1'b1 || rd !== 5'd10 || rd_in !== 64'hAAAA_0000_0000_000A)
      $display("FAIL cont_first got we=%0b rd=%0d data=%h want 1 10 aaaa00000000000a", rd_we, rd, rd_in);
    else passed++;
    tick();
    checks++; if (rd_we !== 1'b1 || rd !== 5'd11 || rd_in !== 64'hBBBB_0000_0000_000B)
      $display("FAIL cont_second got we=%0b rd=%0d data=%h want 1 11 bbbb00000000000b", rd_we, rd, rd_in);
    else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL cont_drained got busy=%0b want 0", busy); else passed++;
    tick();
    checks++; if (rd_we !== 1'b0) $display("FAIL cont_no_third got we=%0b want 0", rd_we); else passed++;
  endtask

  task automatic test_x0();
    alu_valid = 1; alu_rd = 0; alu_data = 64'h55;
    tick();
    idle_inputs();
    checks++; if (rd_we !== 1'b0) $display("FAIL x0_alu got we=%0b want 0", rd_we); else passed++;
    alu_valid = 1; alu_rd = 6; alu_data = 64'h66;
    ld_valid = 1; ld_rd = 0; ld_funct3 = 3'b011; ld_data = 64'h77;
    tick();
    idle_inputs();
    checks++; if (busy !== 1'b1) $display("FAIL x0_queued got busy=%0b want 1", busy); else passed++;
    tick();
    checks++; if (busy !== 1'b0 || rd_we !== 1'b0)
      $display("FAIL x0_pop got busy=%0b we=%0b want 0 0", busy, rd_we); else passed++;
  endtask

  task automatic test_reset_mid();
    alu_valid = 1; alu_rd = 2; alu_data = 64'h22;
    ld_valid = 1; ld_rd = 13; ld_funct3 = 3'b011; ld_data = 64'hD;
    tick();
    ld_rd = 14; ld_data = 64'hE;
    tick();
    idle_inputs();
    checks++; if (busy !== 1'b1 || ld_ready !== 1'b0)
      $display("FAIL rstmid_pre got busy=%0b ready=%0b want 1 0", busy, ld_ready); else passed++;
    rst_n = 1'b0;
    #2;
    model_clear();
    checks++; if (rd_we !== 1'b0 || busy !== 1'b0 || ld_ready !== 1'b1)
      $display("FAIL rstmid_async got we=%0b busy=%0b ready=%0b want 0 0 1", rd_we, busy, ld_ready);
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rd_we !== 1'b0 || busy !== 1'b0)
        $display("FAIL rstmid_stale cycle %0d got we=%0b busy=%0b want 0 0", i, rd_we, busy);
      else passed++;
    end
  endtask

  task automatic test_forward();
    alu_valid = 1; alu_rd = 7; alu_data = 64'hAA;
    tick();
    idle_inputs();
    rs1 = 7; rf_out1 = 64'h11; rs2 = 7; rf_out2 = 64'h33;
    #1;
`ifdef WB_FORWARD_EN
    checks++; if (op1 !== 64'hAA) $display("FAIL fwd_op1 got %h want aa", op1); else passed++;
    checks++; if (op2 !== 64'hAA) $display("FAIL fwd_op2 got %h want aa", op2); else passed++;
`else
    checks++; if (op1 !== 64'h11) $display("FAIL pass_op1 got %h want 11", op1); else passed++;
    checks++; if (op2 !== 64'h33) $display("FAIL pass_op2 got %h want 33", op2); else passed++;
`endif
    rs1 = 0; rs2 = 3;
    #1;
    checks++; if (op1 !== 64'h11) $display("FAIL fwd_x0_op1 got %h want 11", op1); else passed++;
    checks++; if (op2 !== 64'h33) $display("FAIL fwd_miss_op2 got %h want 33", op2); else passed++;
    tick();
    rs1 = 7;
    #1;
    checks++; if (op1 !== 64'h11) $display("FAIL fwd_nowe_op1 got %h want 11", op1); else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      alu_valid  = ($urandom_range(0, 99) < 40);
      alu_rd     = 5'($urandom_range(0, 31));
      alu_data   = {$urandom, $urandom};
      ld_valid   = ($urandom_range(0, 99) < 60);
      ld_rd      = 5'($urandom_range(0, 31));
      ld_funct3  = 3'($urandom_range(0, 7));
      ld_addr_lo = 3'($urandom_range(0, 7));
      ld_data    = {$urandom, $urandom};
      checks++; if (ld_ready !== (mq_rd.size() < DEPTH))
        $display("FAIL rnd_ready it %0d got %0b want %0b", i, ld_ready, mq_rd.size() < DEPTH);
      else passed++;
      tick();
      checks++; if (rd_we !== exp_we)
        $display("FAIL rnd_we it %0d got %0b want %0b", i, rd_we, exp_we);
      else passed++;
      if (exp_we) begin
        checks++; if (rd !== exp_rd || rd_in !== exp_rd_in)
          $display("FAIL rnd_write it %0d got rd=%0d data=%h want rd=%0d data=%h",
                   i, rd, rd_in, exp_rd, exp_rd_in);
        else passed++;
      end
      checks++; if (busy !== (mq_rd.size() != 0))
        $display("FAIL rnd_busy it %0d got %0b want %0b", i, busy, mq_rd.size() != 0);
      else passed++;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_lb_sign();
    test_contention();
    test_x0();
    test_reset_mid();
    test_forward();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
